// File: rtl/cmp_arb_pkg.sv
// Shared helpers for the cmp_arb round-robin wrapper.
package cmp_arb_pkg;

    // Round-robin successor of a requester index among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cmp.sv
// Branch-compare unit: evaluates one branch condition on two operands.
`include "cmp.vh"

module cmp #(
    parameter int WIDTH = 32
) (
    input  logic [`CMP_OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]         src1,
    input  logic [WIDTH-1:0]         src2,
    output logic                     taken
);

    // Decode the op; unknown encodings never take the branch.
    always_comb begin
        taken = 1'b0;
        case (op)
            `CMP_OP_BEQ:  taken = (src1 == src2);
            `CMP_OP_BNE:  taken = (src1 != src2);
            `CMP_OP_BLT:  taken = ($signed(src1) <  $signed(src2));
            `CMP_OP_BGE:  taken = ($signed(src1) >= $signed(src2));
            `CMP_OP_BLTU: taken = (src1 <  src2);
            `CMP_OP_BGEU: taken = (src1 >= src2);
            default:      taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp.vh
// Branch-compare op encodings shared by cmp and its users.
`ifndef CMP_VH
`define CMP_VH

`define CMP_OP_WIDTH 3
`define CMP_OP_BEQ   3'd0
`define CMP_OP_BNE   3'd1
`define CMP_OP_BLT   3'd2
`define CMP_OP_BGE   3'd3
`define CMP_OP_BLTU  3'd4
`define CMP_OP_BGEU  3'd5

`endif

// File: rtl/cmp_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module cmp_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int ID_W = $clog2(NREQ);

    logic found;

    // Two passes: indices ptr..NREQ-1 first, then the wrapped range 0..ptr-1.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = ID_W'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (k < int'(ptr))) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/cmp_arb.sv
// Shares one cmp unit between NREQ requesters with round-robin grant and a
// single registered response slot that can be refilled in the cycle it drains.
`include "cmp.vh"

module cmp_arb
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NREQ-1:0]                i_req_valid,
    output logic [NREQ-1:0]                o_req_ready,
    input  logic [NREQ*`CMP_OP_WIDTH-1:0]  i_req_op,
    input  logic [NREQ*WIDTH-1:0]          i_req_src1,
    input  logic [NREQ*WIDTH-1:0]          i_req_src2,
    output logic                           o_rsp_valid,
    output logic [$clog2(NREQ)-1:0]        o_rsp_id,
    output logic                           o_rsp_taken,
    input  logic                           i_rsp_ready
);

    localparam int ID_W = $clog2(NREQ);
    localparam int OPW  = `CMP_OP_WIDTH;

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  ptr;
    logic             can_accept;
    logic             accept;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_src1;
    logic [WIDTH-1:0] sel_src2;
    logic             cmp_taken;

    cmp_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (i_req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // The slot can take a new result if it is empty or being drained now.
    assign can_accept  = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = i_rst ? '0 : (gnt & {NREQ{can_accept}});
    assign accept      = |(i_req_valid & o_req_ready);

    // Steer the granted requester's fields into the shared compare unit.
    always_comb begin
        sel_op   = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_op   = i_req_op[k*OPW +: OPW];
                sel_src1 = i_req_src1[k*WIDTH +: WIDTH];
                sel_src2 = i_req_src2[k*WIDTH +: WIDTH];
            end
        end
    end

    cmp #(.WIDTH(WIDTH)) u_cmp (
        .op    (sel_op),
        .src1  (sel_src1),
        .src2  (sel_src2),
        .taken (cmp_taken)
    );

    // Response slot and round-robin pointer; accept wins over a plain pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_taken <= 1'b0;
            ptr         <= '0;
        end else if (accept) begin
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= gnt_idx;
            o_rsp_taken <= cmp_taken;
            ptr         <= ID_W'(rr_next(32'(gnt_idx), NREQ));
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_arb.sv
// Bench for cmp_arb with NREQ=2: directed vector table, hand-written
// multi-cycle sequences and a randomized phase, all checked via a
// response scoreboard queue.
module tb_cmp_arb;

    localparam int WIDTH = 32;
    localparam int NREQ  = 2;

    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd2;
    localparam logic [2:0] BGE  = 3'd3;
    localparam logic [2:0] BLTU = 3'd4;
    localparam logic [2:0] BGEU = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_taken;
    logic        rsp_ready;

    always #5 clk = ~clk;

    cmp_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_src1  (req_src1),
        .i_req_src2  (req_src2),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_taken (rsp_taken),
        .i_rsp_ready (rsp_ready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic id;
        logic tk;
    } rsp_t;

    rsp_t q[$];
    int   ptr_m = 0;

    typedef struct {
        logic [1:0]  vld;
        logic [2:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        rr;
        logic [1:0]  ex_rdy;
        logic        ex_id;
        logic        ex_tk;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLT:     return $signed(a) <  $signed(b);
            BGE:     return $signed(a) >= $signed(b);
            BLTU:    return a <  b;
            BGEU:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] vld,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic rr, input logic [1:0] ex_rdy, input logic ex_id, input logic ex_tk);
        vec_t v;
        v.vld = vld; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1; v.rr = rr;
        v.ex_rdy = ex_rdy; v.ex_id = ex_id; v.ex_tk = ex_tk;
        return v;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return {1'b1, 31'($urandom)};
            default: return 32'($urandom);
        endcase
    endfunction

    // One cycle: drive, check ready and slot against the scoreboard at negedge,
    // update the scoreboard, then advance to just after the next rising edge.
    task automatic step(input logic r, input vec_t v, input string tag);
        rst       = r;
        req_valid = v.vld;
        req_op    = {v.op1, v.op0};
        req_src1  = {v.a1, v.a0};
        req_src2  = {v.b1, v.b0};
        rsp_ready = v.rr;
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'(v.ex_rdy));
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, " rsp_id"}, 32'(rsp_id), 32'(q[0].id));
            chk({tag, " rsp_taken"}, 32'(rsp_taken), 32'(q[0].tk));
            if (v.rr) void'(q.pop_front());
        end
        if (r) begin
            q.delete();
            ptr_m = 0;
        end else if (v.ex_rdy != 2'b00) begin
            q.push_back('{id: v.ex_id, tk: v.ex_tk});
            ptr_m = (int'(v.ex_id) + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] m1;
        logic [31:0] m22;
        logic [31:0] m10;
        logic [31:0] m5;
        logic [31:0] m3;
        m1  = 32'hFFFF_FFFF;
        m22 = 32'hFFFF_FFEA;
        m10 = 32'hFFFF_FFF6;
        m5  = 32'hFFFF_FFFB;
        m3  = 32'hFFFF_FFFD;

        //         vld    op0   a0   b0   op1   a1   b1   rr  rdy    id    tk
        tbl[0]  = mk(2'b00, BEQ,  0,   0,   BEQ,  0,   0,   1, 2'b00, 1'b0, 1'b0);
        tbl[1]  = mk(2'b10, BEQ,  0,   0,   BLT,  m22, 2,   1, 2'b10, 1'b1, 1'b1);
        tbl[2]  = mk(2'b11, BEQ,  13,  13,  BNE,  13,  13,  1, 2'b01, 1'b0, 1'b1);
        tbl[3]  = mk(2'b11, BEQ,  13,  13,  BNE,  13,  13,  1, 2'b10, 1'b1, 1'b0);
        tbl[4]  = mk(2'b11, BEQ,  13,  13,  BNE,  13,  13,  1, 2'b01, 1'b0, 1'b1);
        tbl[5]  = mk(2'b11, BEQ,  13,  13,  BNE,  13,  13,  1, 2'b10, 1'b1, 1'b0);
        tbl[6]  = mk(2'b00, BEQ,  0,   0,   BEQ,  0,   0,   1, 2'b00, 1'b0, 1'b0);
        tbl[7]  = mk(2'b01, BGE,  m5,  m5,  BEQ,  0,   0,   1, 2'b01, 1'b0, 1'b1);
        tbl[8]  = mk(2'b01, BLTU, 2,   m1,  BEQ,  0,   0,   1, 2'b01, 1'b0, 1'b1);
        tbl[9]  = mk(2'b10, BEQ,  0,   0,   BGEU, 1,   m10, 1, 2'b10, 1'b1, 1'b0);
        tbl[10] = mk(2'b10, BEQ,  0,   0,   3'd7, 4,   4,   1, 2'b10, 1'b1, 1'b0);
        tbl[11] = mk(2'b11, BLT,  5,   m3,  BEQ,  1,   2,   1, 2'b01, 1'b0, 1'b0);
        tbl[12] = mk(2'b00, BEQ,  0,   0,   BEQ,  0,   0,   1, 2'b00, 1'b0, 1'b0);

        // Reset: ready stays low even with requests presented.
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset rsp_taken", 32'(rsp_taken), 0);
        chk("reset ready idle", 32'(req_ready), 0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("reset ready busy", 32'(req_ready), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) step(1'b0, tbl[i], $sformatf("vec%0d", i));

        // Back-pressure: slot holds (0, BGEU -10/1 = 1) for three stalled cycles.
        step(1'b0, mk(2'b01, BGEU, m10, 1, BEQ, 0, 0, 1, 2'b01, 1'b0, 1'b1), "bp fill");
        for (int i = 0; i < 3; i++)
            step(1'b0, mk(2'b10, BEQ, 0, 0, BEQ, 7, 7, 0, 2'b00, 1'b0, 1'b0), $sformatf("bp stall%0d", i));
        step(1'b0, mk(2'b10, BEQ, 0, 0, BEQ, 7, 7, 1, 2'b10, 1'b1, 1'b1), "bp release");
        step(1'b0, mk(2'b00, BEQ, 0, 0, BEQ, 0, 0, 0, 2'b00, 1'b0, 1'b0), "bp nobubble");
        step(1'b0, mk(2'b00, BEQ, 0, 0, BEQ, 0, 0, 1, 2'b00, 1'b0, 1'b0), "bp drain");

        // Reset with a pending result: slot dropped, pointer back to 0.
        step(1'b0, mk(2'b01, BLTU, 2, m1, BEQ, 0, 0, 1, 2'b01, 1'b0, 1'b1), "rst fill");
        step(1'b1, mk(2'b11, BEQ, 0, 0, BEQ, 0, 0, 0, 2'b00, 1'b0, 1'b0), "rst mid");
        step(1'b0, mk(2'b11, BEQ, 0, 0, BEQ, 0, 0, 1, 2'b01, 1'b0, 1'b1), "rst ptr0");

        // Randomized phase against the bench's own arbiter and compare model.
        for (int c = 0; c < 1000; c++) begin
            int  g;
            logic can;
            v.vld = 2'($urandom_range(0, 3));
            v.op0 = 3'($urandom_range(0, 7));
            v.op1 = 3'($urandom_range(0, 7));
            v.a0  = rnd_opnd();
            v.b0  = ($urandom_range(0, 3) == 0) ? v.a0 : rnd_opnd();
            v.a1  = rnd_opnd();
            v.b1  = ($urandom_range(0, 3) == 0) ? v.a1 : rnd_opnd();
            v.rr  = ($urandom_range(0, 3) != 0);
            can   = (q.size() == 0) || v.rr;
            g = -1;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (ptr_m + i) % NREQ;
                if (g < 0 && v.vld[k]) g = k;
            end
            v.ex_rdy = 2'b00;
            v.ex_id  = 1'b0;
            v.ex_tk  = 1'b0;
            if (g >= 0 && can) begin
                v.ex_rdy[g] = 1'b1;
                v.ex_id     = (g == 1);
                v.ex_tk     = (g == 0) ? ref_cmp(v.op0, v.a0, v.b0) : ref_cmp(v.op1, v.a1, v.b1);
            end
            step(1'b0, v, $sformatf("rnd%0d", c));
        end

        step(1'b0, mk(2'b00, BEQ, 0, 0, BEQ, 0, 0, 1, 2'b00, 1'b0, 1'b0), "final drain");
        step(1'b0, mk(2'b00, BEQ, 0, 0, BEQ, 0, 0, 1, 2'b00, 1'b0, 1'b0), "final idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_arb.md
Name: cmp_arb

Overview:
- Shares one `cmp` branch-compare unit between NREQ requesters, e.g. multiple issue slots or a branch unit plus a verification port.
- Round-robin arbiter with a valid/ready request handshake per requester and a single registered response slot.
- The response slot carries the result plus the requester index.
- Sits between issue logic and the branch-resolution / PC-redirect logic.

Parameters:
- WIDTH, 32, operand width passed to the `cmp` instance.
- NREQ, 2, number of requesters; legal values 2..8.
- ID_W, $clog2(NREQ), width of the requester index (derived localparam, not overridable).

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_req_valid  input  NREQ  bit k: requester k presents a compare.
- o_req_ready  output  NREQ  bit k: requester k's request is accepted this cycle.
- i_req_op  input  NREQ*`CMP_OP_WIDTH  flattened; slice k = op of requester k.
- i_req_src1  input  NREQ*WIDTH  flattened; slice k = src1 of requester k.
- i_req_src2  input  NREQ*WIDTH  flattened; slice k = src2 of requester k.
- o_rsp_valid  output  1  response slot holds a result.
- o_rsp_id  output  ID_W  index of the requester that owns the result.
- o_rsp_taken  output  1  compare result, registered.
- i_rsp_ready  input  1  consumer takes the response this cycle.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_taken=0.
  - Round-robin pointer ptr=0.
  - A pending response is discarded; reset asserted mid-operation loses it silently.
  - While i_rst=1, o_req_ready=0.
- can_accept = !o_rsp_valid | i_rsp_ready (combinational).
- Grant:
  - grant is one-hot: the first k with i_req_valid[k]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrap-around).
  - grant is all-zero if no request is valid.
- o_req_ready = grant & {NREQ{can_accept}}.
  - Ready depends combinationally on i_req_valid and i_rsp_ready; that is the intended behaviour.
  - Requesters must not make valid depend on ready.
- Accept: any bit of (i_req_valid & o_req_ready) is set. On accept at edge:
  - Latch o_rsp_taken from `cmp`, fed by the granted requester's op/src1/src2.
  - Latch o_rsp_id = index of granted requester; set o_rsp_valid=1.
  - ptr <= (granted index + 1) mod NREQ.
- Latency: exactly 1 cycle from accept to o_rsp_valid=1. Throughput is 1 result per cycle while i_rsp_ready=1.
- Pop without accept (o_rsp_valid & i_rsp_ready, no accept): o_rsp_valid <= 0. o_rsp_id and o_rsp_taken hold their last values.
- Simultaneous pop and accept: the slot is overwritten with the new result and o_rsp_valid stays 1. No bubble.
- Stall: while o_rsp_valid=1 and i_rsp_ready=0:
  - o_rsp_valid, o_rsp_id and o_rsp_taken are stable.
  - All o_req_ready=0.
  - ptr does not change.
- No request valid: ptr unchanged.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Request fields are sampled only in the accept cycle. A requester may change fields while not ready.
- Op handling: op is forwarded to `cmp` unchanged. An unknown op encoding yields whatever `cmp` produces (taken=0); the arbiter does no checking.
- Signed/unsigned semantics are owned entirely by `cmp`.

Decomposition:
- Constants: CMP_OP_* encodings and `CMP_OP_WIDTH` stay in cmp.vh, which is included, not duplicated. No new shared constants.
- Sub-module cmp_rr_pick (NREQ param):
  - Inputs: request vector, ptr.
  - Output: one-hot grant plus encoded index.
  - Purely combinational; reusable by later arbiters.
- Existing `cmp` is instantiated once, with WIDTH passed through.
- Top level holds ptr, the response register and the handshake logic.

Test Plan:
- Reset then idle:
  - Stimulus: i_rst=1 for 2 cycles, all valid=0.
  - Required: o_rsp_valid=0, o_rsp_id=0, o_rsp_taken=0, o_req_ready=0; after release, o_req_ready stays 0 while no request is valid.
- Single request:
  - Stimulus: req1 BLT src1=-22 src2=2, i_rsp_ready=1.
  - Required: ready[1]=1 in the same cycle; next cycle o_rsp_valid=1, o_rsp_id=1, o_rsp_taken=1, then ptr=0.
- Round robin:
  - Stimulus: req0 BEQ 13/13 and req1 BNE 13/13 both held valid, i_rsp_ready=1.
  - Required: grants alternate 0,1,0,1; responses (id,taken) = (0,1), (1,0), (0,1), ...
- Back-pressure:
  - Stimulus: slot holds (id=0, BGEU -10/1, taken=1), i_rsp_ready=0 for 3 cycles, req1 valid.
  - Required: outputs stable and o_req_ready=0 for all 3 cycles; when i_rsp_ready=1, ready[1]=1 the same cycle and the new result appears the next cycle with no bubble.
- Reset mid-operation:
  - Stimulus: slot valid with BLTU 2/-1 result, assert i_rst while i_rsp_ready=0.
  - Required: o_rsp_valid=0 next cycle; ptr=0, so req0 wins against req1 on the first cycle after reset.
- Randomized cross-check (1000 cycles):
  - Stimulus: random valid/ops/operands on all 6 ops, random i_rsp_ready.
  - Required: every response matches the reference-model compare of the accepted request; no accepted request is lost or duplicated; starvation bound is NREQ accepts.
